// File: rtl/iiitb_r2_4bit_div_if.sv
// Start/done handshake and operand/result bundle for the radix-2 restoring divider.
// The requester drives the master side; the divider implements the slave side.
interface iiitb_r2_4bit_div_if #(
    parameter int N = 4
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/iiitb_r2_4bit_div.sv
// Radix-2 sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define IIITB_DIV_SIGNED_EN for two's-complement operands with a sign-correction (FIX) state.
module iiitb_r2_4bit_div #(
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    iiitb_r2_4bit_div_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

`ifdef IIITB_DIV_SIGNED_EN
    localparam state_t RUN_EXIT = FIX;
`else
    localparam state_t RUN_EXIT = DONE;
`endif

    state_t         state, state_next;
    logic [N-1:0]   r;
    logic [N-1:0]   qs;
    logic [N-1:0]   dvs;
    logic [CW-1:0]  count;
    logic [N-1:0]   quotient, remainder;
    logic           div_by_zero, overflow;

    logic [2*N-1:0] mag_dividend;
    logic [N-1:0]   mag_divisor;
    logic           zero_div, pre_overflow;
    logic [N:0]     shifted, trial;
    logic [N-1:0]   r_step, qs_step;
    logic [N-1:0]   res_q, res_r;
    logic           accept, finish;

    assign zero_div = (bus.divisor == '0);

`ifdef IIITB_DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic neg_q, neg_r;

    assign dvd_neg      = bus.dividend[2*N-1];
    assign dvs_neg      = bus.divisor[N-1];
    assign mag_dividend = dvd_neg ? -bus.dividend : bus.dividend;
    assign mag_divisor  = dvs_neg ? -bus.divisor : bus.divisor;
    // The most negative dividend has no positive magnitude, so it is always flagged.
    assign pre_overflow = (bus.dividend == {1'b1, {(2*N-1){1'b0}}})
                       || ((mag_dividend >> (N - 1)) >= {{N{1'b0}}, mag_divisor});
    assign res_q        = neg_q ? -qs : qs;
    assign res_r        = neg_r ? -r : r;
`else
    assign mag_dividend = bus.dividend;
    assign mag_divisor  = bus.divisor;
    assign pre_overflow = (bus.dividend[2*N-1:N] >= bus.divisor);
    assign res_q        = qs_step;
    assign res_r        = r_step;
`endif

    // Partial remainder stays below the divisor, so its extra top bit is only needed in the trial.
    assign shifted = {r, qs[N-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign r_step  = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    assign qs_step = {qs[N-2:0], ~trial[N]};

    assign accept = (state == IDLE) && bus.start;
    assign finish = (state != IDLE) && (state_next == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = (zero_div || pre_overflow) ? DONE : RUN;
            RUN:  if (count == CW'(1)) state_next = RUN_EXIT;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            r           <= '0;
            qs          <= '0;
            dvs         <= '0;
            count       <= CW'(N);
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef IIITB_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                div_by_zero <= zero_div;
                overflow    <= !zero_div && pre_overflow;
                count       <= CW'(N);
                r           <= mag_dividend[2*N-1:N];
                qs          <= mag_dividend[N-1:0];
                dvs         <= mag_divisor;
`ifdef IIITB_DIV_SIGNED_EN
                neg_q       <= dvd_neg ^ dvs_neg;
                neg_r       <= dvd_neg;
`endif
                if (zero_div) begin
                    quotient  <= '1;
                    remainder <= bus.dividend[N-1:0];
                end else if (pre_overflow) begin
                    quotient  <= '0;
                    remainder <= '0;
                end
            end else if (state == RUN) begin
                count <= count - 1'b1;
                r     <= r_step;
                qs    <= qs_step;
            end
            if (finish) begin
                quotient  <= res_q;
                remainder <= res_r;
            end
        end
    end

    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
    assign bus.overflow    = overflow;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_iiitb_r2_4bit_div.sv
// Directed self-checking bench for iiitb_r2_4bit_div (N=4), unsigned or signed build.
module tb_iiitb_r2_4bit_div;
    localparam int N = 4;
`ifdef IIITB_DIV_SIGNED_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat, bcnt, dcnt;
    logic [N-1:0] q_seen, r_seen;

    iiitb_r2_4bit_div_if #(.N(N)) bus ();

    iiitb_r2_4bit_div #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; lat counts edges from the capture edge until done is seen.
    task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs,
                         output int lat_o, output int busy_o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = dvd;
        bus.divisor = dvs;
        lat_o = 0;
        busy_o = 0;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat_o++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_o++;
        end
    endtask

    task automatic chk_res(input string tag, input int lat_exp,
                           input logic [3:0] q, input logic [3:0] r,
                           input logic dz, input logic ov);
        chk({tag, "_lat"}, lat, lat_exp);
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, bus.remainder, r);
        chk({tag, "_dz"}, bus.div_by_zero, dz);
        chk({tag, "_ov"}, bus.overflow, ov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
        reset_n = 1'b1;

`ifdef IIITB_DIV_SIGNED_EN
        do_op(8'hDB, 4'h5, lat, bcnt);
        chk_res("s_m37_5", 6, 4'h9, 4'hE, 1'b0, 1'b0);
        chk("s_m37_5_busy", bcnt, 5);
        do_op(8'hD6, 4'h5, lat, bcnt);
        chk_res("s_m42_5_ov", 1, 4'h0, 4'h0, 1'b0, 1'b1);
        do_op(8'h25, 4'hB, lat, bcnt);
        chk_res("s_37_m5", 6, 4'h9, 4'h2, 1'b0, 1'b0);
        do_op(8'hDB, 4'hB, lat, bcnt);
        chk_res("s_m37_m5", 6, 4'h7, 4'hE, 1'b0, 1'b0);
        do_op(8'hC9, 4'h7, lat, bcnt);
        chk_res("s_m55_7", 6, 4'h9, 4'hA, 1'b0, 1'b0);
        do_op(8'h80, 4'h1, lat, bcnt);
        chk_res("s_minneg_ov", 1, 4'h0, 4'h0, 1'b0, 1'b1);
`else
        do_op(8'd100, 4'd9, lat, bcnt);
        chk_res("u_100_9", 5, 4'd11, 4'd1, 1'b0, 1'b0);
        chk("u_100_9_busy", bcnt, 4);
        @(negedge clk);
        chk("u_after_done", bus.done, 0);
        chk("u_after_busy", bus.busy, 0);
        chk("u_held_q", bus.quotient, 4'd11);
        do_op(8'd200, 4'd3, lat, bcnt);
        chk_res("u_200_3_ov", 1, 4'h0, 4'h0, 1'b0, 1'b1);
        do_op(8'hEF, 4'hF, lat, bcnt);
        chk_res("u_239_15", 5, 4'hF, 4'hE, 1'b0, 1'b0);
        do_op(8'h90, 4'h9, lat, bcnt);
        chk_res("u_ov_edge", 1, 4'h0, 4'h0, 1'b0, 1'b1);
        do_op(8'h07, 4'h1, lat, bcnt);
        chk_res("u_7_1", 5, 4'h7, 4'h0, 1'b0, 1'b0);
`endif

        do_op(8'h32, 4'h0, lat, bcnt);
        chk_res("dz", 1, 4'hF, 4'h2, 1'b1, 1'b0);
        do_op(8'd15, 4'd4, lat, bcnt);
        chk_res("dz_clear", LAT, 4'd3, 4'd3, 1'b0, 1'b0);

        // Start pulse with other operands while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd22; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd7; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        dcnt = 0;
        q_seen = '0;
        r_seen = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dcnt++;
                q_seen = bus.quotient;
                r_seen = bus.remainder;
            end
        end
        chk("ign_done_cnt", dcnt, 1);
        chk("ign_q", q_seen, 4'd4);
        chk("ign_r", r_seen, 4'd2);

        // Start held through DONE is taken on the following IDLE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd2;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) break;
        end
        chk("hold_lat1", lat, LAT);
        @(negedge clk);
        chk("hold_idle_busy", bus.busy, 0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        chk("hold_lat2", lat, LAT);
        chk("hold_q", bus.quotient, 4'd4);
        chk("hold_r", bus.remainder, 4'd1);

        // Reset during RUN aborts the operation without a done pulse.
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd22; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remainder, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        do_op(8'd15, 4'd4, lat, bcnt);
        chk_res("after_abort", LAT, 4'd3, 4'd3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
